// File: rtl/psum_accumulator.sv
// Sums ACC_TERMS unsigned 17-bit adder results into one 16-bit saturated word.
// Valid/ready on both sides; one result is held until the downstream takes it.
module psum_accumulator #(
  parameter int ACC_TERMS = 3,
  parameter int ACC_W     = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic        in_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat
);

  // state | meaning
  // IDLE  | acc=0, cnt=0, waiting for the first term
  // ACC   | partial sum held, 0 < cnt < ACC_TERMS
  // HOLD  | result presented on out_*, waiting for out_ready

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]      r_out_data, w_out_data_nxt;
  logic             r_out_sat, w_out_sat_nxt;
  logic             r_live;

  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_total;
  logic             w_total_ovf;
  logic             w_accept;

  assign w_term      = ACC_W'({in_cout, in_sum});
  assign w_total     = r_acc + w_term;
  assign w_total_ovf = (w_total > ACC_W'(16'hFFFF));

  // r_live keeps in_ready low until the first edge after reset release
  assign in_ready  = r_live && (r_state != HOLD);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= 16'h0000;
      r_out_sat  <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_out_data <= w_out_data_nxt;
      r_out_sat  <= w_out_sat_nxt;
      r_live     <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_out_data_nxt = r_out_data;
    w_out_sat_nxt  = r_out_sat;

    if (flush) begin
      // the last result stays on out_data; only the handshake is withdrawn
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            if (r_cnt == LAST_CNT) begin
              w_state_nxt    = HOLD;
              w_out_data_nxt = w_total_ovf ? 16'hFFFF : w_total[15:0];
              w_out_sat_nxt  = w_total_ovf;
            end else begin
              w_state_nxt = ACC;
              w_acc_nxt   = w_total;
              w_cnt_nxt   = r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 3-term instance and a 1-term instance
// driven on the falling edge and observed on the falling edge.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_cout, out_ready;
  logic [15:0] in_sum;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_data;

  logic        flush1, in_valid1, in_cout1, out_ready1;
  logic [15:0] in_sum1;
  logic        in_ready1, out_valid1, out_sat1;
  logic [15:0] out_data1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psum_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  psum_accumulator #(.ACC_TERMS(1), .ACC_W(17)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_sum(in_sum1), .in_cout(in_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_sat(out_sat1)
  );

  // presents three terms on consecutive cycles; returns on the falling edge
  // after the third term was taken, with in_valid dropped
  task automatic send3(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c);
    @(negedge clk); in_valid = 1'b1; {in_cout, in_sum} = a;
    @(negedge clk); {in_cout, in_sum} = b;
    @(negedge clk); {in_cout, in_sum} = c;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cout = 1'b0; in_sum = 16'h0; out_ready = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b0; in_cout1 = 1'b0; in_sum1 = 16'h0; out_ready1 = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL rst_out_sat: got %b want 0", out_sat); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_pre_edge: got %b want 0", in_ready); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send3(17'h01000, 17'h02000, 17'h00003);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 16'h3003) begin bad++; $display("FAIL basic_data: got %h want 3003", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", out_sat); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_ready: got %b want 0", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_saturate;
    out_ready = 1'b1;
    send3(17'h10000, 17'h00001, 17'h00000);
    total++; if (out_data !== 16'hFFFF) begin bad++; $display("FAIL sat_data: got %h want ffff", out_data); end
    total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", out_sat); end
    @(negedge clk);
    send3(17'h0FFFE, 17'h00001, 17'h00000);
    total++; if (out_data !== 16'hFFFF) begin bad++; $display("FAIL edge_ffff_data: got %h want ffff", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL edge_ffff_sat: got %b want 0", out_sat); end
    @(negedge clk);
    send3(17'h1FFFF, 17'h00001, 17'h00000);
    total++; if (out_data !== 16'hFFFF) begin bad++; $display("FAIL nowrap_data: got %h want ffff", out_data); end
    total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL nowrap_sat: got %b want 1", out_sat); end
    @(negedge clk);
  endtask

  task automatic test_hold_stall;
    out_ready = 1'b0;
    send3(17'h00010, 17'h00020, 17'h00030);
    in_valid = 1'b1; {in_cout, in_sum} = 17'h00111;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (out_data !== 16'h0060) begin bad++; $display("FAIL stall_data[%0d]: got %h want 0060", i, out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_data !== 16'h0060) begin bad++; $display("FAIL stall_end_data: got %h want 0060", out_data); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    send3(17'h00005, 17'h00006, 17'h00007);
    total++; if (out_data !== 16'h0012) begin bad++; $display("FAIL stall_newsum_data: got %h want 0012", out_data); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    in_valid = 1'b1; {in_cout, in_sum} = 17'h00100;
    @(negedge clk); {in_cout, in_sum} = 17'h00200;
    @(negedge clk); {in_cout, in_sum} = 17'h04000; flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    total++; if (out_data !== 16'h0012) begin bad++; $display("FAIL flush_keep_data: got %h want 0012", out_data); end
    out_ready = 1'b0;
    send3(17'h00001, 17'h00002, 17'h00003);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_after_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 16'h0006) begin bad++; $display("FAIL flush_after_data: got %h want 0006", out_data); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_hold_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'h0006) begin bad++; $display("FAIL flush_hold_data: got %h want 0006", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_hold_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; {in_cout, in_sum} = 17'h00100;
    @(negedge clk); {in_cout, in_sum} = 17'h00200;
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b want 0", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b0;
    send3(17'h00001, 17'h00001, 17'h00001);
    total++; if (out_data !== 16'h0003) begin bad++; $display("FAIL rstmid_data: got %h want 0003", out_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rsthold_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rsthold_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rsthold_data: got %h want 0000", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rsthold_ready: got %b want 0", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rsthold_release_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rsthold_release_valid: got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_single_term;
    logic [16:0] terms [4];
    logic [15:0] exp_data [4];
    logic        exp_sat [4];
    terms    = '{17'h00005, 17'h0FFFF, 17'h10000, 17'h01234};
    exp_data = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h1234};
    exp_sat  = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL one_ready[%0d]: got %b want 1", k, in_ready1); end
      total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL one_idle_valid[%0d]: got %b want 0", k, out_valid1); end
      in_valid1 = 1'b1; {in_cout1, in_sum1} = terms[k];
      @(negedge clk);
      total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL one_valid[%0d]: got %b want 1", k, out_valid1); end
      total++; if (out_data1 !== exp_data[k]) begin bad++; $display("FAIL one_data[%0d]: got %h want %h", k, out_data1, exp_data[k]); end
      total++; if (out_sat1 !== exp_sat[k]) begin bad++; $display("FAIL one_sat[%0d]: got %b want %b", k, out_sat1, exp_sat[k]); end
    end
    @(negedge clk); in_valid1 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturate;
    test_hold_stall;
    test_flush;
    test_reset_mid;
    test_single_term;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
